// File: rtl/opl_timer_bank.sv
// OPL-style timer bank: NUM_TIMERS up-counting timers with per-timer tick rate,
// mask/flag status byte, one-shot mode and registered counter readback.
module opl_timer_lane #(
  parameter int               TIMER_W = 8,
  parameter int               SUB_W   = 13,
  parameter logic [SUB_W-1:0] RELOAD  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TIMER_W-1:0] preset_i,
  input  logic               mode_i,
  input  logic               start_wr_i,
  input  logic               start_val_i,
  input  logic               clr_i,
  output logic               raw_o,
  output logic [TIMER_W-1:0] cnt_o
);
  logic               start_q, start_d;
  logic               raw_q, raw_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               tick, ovf;

  assign tick = start_q && (sub_q == '0);
  assign ovf  = tick && (&cnt_q);

  always_comb begin
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    start_d = start_q;
    raw_d   = raw_q;
    if (start_q) begin
      if (tick) begin
        sub_d = RELOAD;
        cnt_d = ovf ? preset_i : cnt_q + 1'b1;
      end else begin
        sub_d = sub_q - 1'b1;
      end
    end else if (start_wr_i && start_val_i) begin
      cnt_d = preset_i;
      sub_d = RELOAD;
    end
    // a start write on the overflow edge overrides the one-shot auto-stop
    if (ovf && mode_i) start_d = 1'b0;
    if (start_wr_i)    start_d = start_val_i;
    if (clr_i) raw_d = 1'b0;
    if (ovf)   raw_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      raw_q   <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= '0;
    end else begin
      start_q <= start_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
    end
  end

  assign raw_o = raw_q;
  assign cnt_o = cnt_q;
endmodule

module opl_timer_bank #(
  parameter int         NUM_TIMERS  = 2,
  parameter int         TIMER_W     = 8,
  parameter int         BASE_PERIOD = 1717,
  parameter int         PERIOD_W    = 13,
  parameter int         DIV_SHIFT   = 2,
  parameter logic [8:0] PRESET_BASE = 9'h002,
  parameter logic [8:0] CTRL_INDEX  = 9'h004,
  parameter logic [8:0] MODE_INDEX  = 9'h005
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         addr,
  input  logic [7:0]         din,
  input  logic               we,
  output logic [7:0]         dout,
  output logic               irq_n,
  input  logic [1:0]         count_sel,
  output logic [TIMER_W-1:0] count_out
);
  localparam int SUB_W = PERIOD_W + DIV_SHIFT * (NUM_TIMERS - 1);

  logic                                 we_q;
  logic [8:0]                           idx_q;
  logic [NUM_TIMERS-1:0][TIMER_W-1:0]   preset_q;
  logic [NUM_TIMERS-1:0]                mask_q, mode_q;
  logic [TIMER_W-1:0]                   count_q, count_d;
  logic [NUM_TIMERS-1:0][TIMER_W-1:0]   cnt;
  logic [NUM_TIMERS-1:0]                raw, vis, pre_hit;
  logic                                 wr, idx_wr, dat_wr, ctrl_hit, clr_wr, cfg_wr, mode_hit;
  logic                                 irq;
  logic [7:0]                           status;

  assign wr       = we & ~we_q;
  assign idx_wr   = wr & ~addr[0];
  assign dat_wr   = wr &  addr[0];
  assign ctrl_hit = dat_wr && (idx_q == CTRL_INDEX);
  assign clr_wr   = ctrl_hit &  din[7];
  assign cfg_wr   = ctrl_hit & ~din[7];
  assign mode_hit = dat_wr && (idx_q == MODE_INDEX);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    localparam logic [SUB_W-1:0] RL = SUB_W'(((BASE_PERIOD + 1) << (DIV_SHIFT * i)) - 1);
    assign pre_hit[i] = dat_wr && (idx_q == PRESET_BASE + 9'(i));
    assign vis[i]     = raw[i] & ~mask_q[i];

    opl_timer_lane #(
      .TIMER_W (TIMER_W),
      .SUB_W   (SUB_W),
      .RELOAD  (RL)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .preset_i    (preset_q[i]),
      .mode_i      (mode_q[i]),
      .start_wr_i  (cfg_wr),
      .start_val_i (din[i]),
      .clr_i       (clr_wr & ~din[6-i]),
      .raw_o       (raw[i]),
      .cnt_o       (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      idx_q    <= '0;
      preset_q <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      count_q  <= '0;
    end else begin
      we_q    <= we;
      count_q <= count_d;
      if (idx_wr)   idx_q  <= {addr[1], din};
      if (mode_hit) mode_q <= din[NUM_TIMERS-1:0];
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (pre_hit[i]) preset_q[i] <= din[TIMER_W-1:0];
        if (cfg_wr)     mask_q[i]   <= din[6-i];
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      if (count_sel == 2'(i)) count_d = cnt[i];
  end

  // flag0 sits at bit 6, flag1 at bit 5, flag2 at bit 4
  always_comb begin
    status    = 8'h00;
    status[7] = irq;
    for (int i = 0; i < NUM_TIMERS; i++) status[6-i] = vis[i];
  end

  assign irq       = |vis;
  assign irq_n     = ~irq;
  assign dout      = (addr == 2'b00) ? status : 8'hFF;
  assign count_out = count_q;
endmodule

// File: tb/tb_opl_timer_bank.sv
// Bench for opl_timer_bank: directed scenarios with literal expectations plus
// random bus traffic, all compared each cycle against a behavioural model.
module tb_opl_timer_bank;
  localparam int NT = 2;
  localparam int BP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       we = 1'b0;
  logic [1:0] count_sel = 2'b00;
  logic [7:0] dout;
  logic       irq_n;
  logic [7:0] count_out;

  int checks = 0;
  int errors = 0;

  opl_timer_bank #(.NUM_TIMERS(NT), .TIMER_W(8), .BASE_PERIOD(BP), .PERIOD_W(13),
                   .DIV_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we),
    .dout(dout), .irq_n(irq_n), .count_sel(count_sel), .count_out(count_out));

  always #5 clk = ~clk;

  // behavioural model
  bit [7:0] m_pre  [NT];
  bit       m_mask [NT];
  bit       m_mode [NT];
  bit       m_run  [NT];
  bit       m_raw  [NT];
  int       m_cnt  [NT];
  int       m_left [NT];
  bit       m_we   = 1'b0;
  bit [8:0] m_idx  = '0;
  int       m_cout = 0;

  function automatic int per(int i);
    return (BP + 1) << (2 * i);
  endfunction

  function automatic logic [7:0] exp_status();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < NT; i++)
      if (m_raw[i] && !m_mask[i]) begin
        s[6-i] = 1'b1;
        s[7]   = 1'b1;
      end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    bit       wr;
    bit       ovf  [NT];
    bit       orun [NT];
    bit [7:0] opre [NT];
    if (!rst_n) begin
      m_we = 1'b0; m_idx = '0; m_cout = 0;
      for (int i = 0; i < NT; i++) begin
        m_pre[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_run[i] = 0;
        m_raw[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
      end
    end else begin
      wr   = we && !m_we;
      m_we = we;
      m_cout = 0;
      if (int'(count_sel) < NT) m_cout = m_cnt[count_sel];
      for (int i = 0; i < NT; i++) begin
        orun[i] = m_run[i];
        opre[i] = m_pre[i];
        ovf[i]  = 1'b0;
        if (m_run[i]) begin
          if (m_left[i] > 0) m_left[i]--;
          else begin
            m_left[i] = per(i) - 1;
            if (m_cnt[i] == 255) begin
              ovf[i]   = 1'b1;
              m_cnt[i] = m_pre[i];
              if (m_mode[i]) m_run[i] = 1'b0;
            end else m_cnt[i]++;
          end
        end
      end
      if (wr && !addr[0]) m_idx = {addr[1], din};
      else if (wr) begin
        if (m_idx == 9'h005) for (int i = 0; i < NT; i++) m_mode[i] = din[i];
        for (int i = 0; i < NT; i++) if (m_idx == 9'(2 + i)) m_pre[i] = din;
        if (m_idx == 9'h004) begin
          if (din[7]) begin
            for (int i = 0; i < NT; i++) if (!din[6-i]) m_raw[i] = 1'b0;
          end else begin
            for (int i = 0; i < NT; i++) begin
              m_mask[i] = din[6-i];
              if (din[i] && !orun[i]) begin
                m_cnt[i]  = opre[i];
                m_left[i] = per(i) - 1;
              end
              m_run[i] = din[i];
            end
          end
        end
      end
      for (int i = 0; i < NT; i++) if (ovf[i]) m_raw[i] = 1'b1;
    end
  end

  always @(posedge clk) begin : cmp
    logic [7:0] st;
    #2;
    st = exp_status();
    chk("dout", dout, (addr == 2'b00) ? st : 8'hFF);
    chk("irq_n", {7'b0, irq_n}, {7'b0, ~st[7]});
    chk("count_out", count_out, 8'(m_cout));
  end

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk); we = 1'b0; addr = 2'b00;
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [8:0] idx, input logic [7:0] d);
    bus_wr({idx[8], 1'b0}, idx[7:0]);
    bus_wr({idx[8], 1'b1}, d);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_status", dout, 8'h00);
    chk("rst_irq_n", {7'b0, irq_n}, 8'h01);
    chk("rst_count", count_out, 8'h00);
    addr = 2'b01; #1;
    chk("rst_dout_addr1", dout, 8'hFF);
    addr = 2'b00;
    @(negedge clk);

    // timer 0 overflow 8 cycles after the start edge, then reload to FE
    wr_reg(9'h002, 8'hFE);
    wr_reg(9'h004, 8'h01);
    repeat (6) @(posedge clk); #2;
    chk("t0_before_ovf_irq_n", {7'b0, irq_n}, 8'h01);
    @(posedge clk); #2;
    chk("t0_ovf_irq_n", {7'b0, irq_n}, 8'h00);
    chk("t0_ovf_status", dout, 8'hC0);
    chk("t0_cnt_before_reload", count_out, 8'hFF);
    @(posedge clk); #2;
    chk("t0_cnt_reload", count_out, 8'hFE);
    @(negedge clk);
    bus_wr(2'b01, 8'h00);
    bus_wr(2'b01, 8'h80);
    chk("t0_cleared", dout, 8'h00);

    // timer 1 overflow 16 cycles after start
    wr_reg(9'h003, 8'hFF);
    wr_reg(9'h004, 8'h02);
    repeat (14) @(posedge clk); #2;
    chk("t1_before_ovf", dout, 8'h00);
    @(posedge clk); #2;
    chk("t1_ovf_status", dout, 8'hA0);
    chk("t1_ovf_irq_n", {7'b0, irq_n}, 8'h00);
    @(negedge clk);
    bus_wr(2'b01, 8'h00);
    bus_wr(2'b01, 8'h80);
    chk("t1_cleared", dout, 8'h00);

    // masked overflow stays hidden, unmask exposes it
    wr_reg(9'h002, 8'hFF);
    wr_reg(9'h004, 8'h41);
    repeat (5) @(negedge clk);
    chk("mask_status", dout, 8'h00);
    chk("mask_irq_n", {7'b0, irq_n}, 8'h01);
    bus_wr(2'b01, 8'h01);
    chk("unmask_status", dout, 8'hC0);
    bus_wr(2'b01, 8'h00);
    bus_wr(2'b01, 8'h80);
    chk("mask_cleared", dout, 8'h00);

    // one-shot: single overflow, counter parks at preset
    wr_reg(9'h005, 8'h01);
    wr_reg(9'h002, 8'hFF);
    wr_reg(9'h004, 8'h01);
    repeat (10) @(negedge clk);
    chk("oneshot_status", dout, 8'hC0);
    chk("oneshot_count", count_out, 8'hFF);
    bus_wr(2'b01, 8'h80);
    repeat (20) @(negedge clk);
    chk("oneshot_no_reflag", dout, 8'h00);
    chk("oneshot_count_hold", count_out, 8'hFF);
    wr_reg(9'h005, 8'h00);

    // clear on the overflow edge with we held for 10 cycles
    wr_reg(9'h002, 8'hFF);
    wr_reg(9'h004, 8'h01);
    repeat (2) @(negedge clk);
    addr = 2'b01; din = 8'h80; we = 1'b1;
    @(posedge clk); #2;
    chk("clr_on_ovf_irq_n", {7'b0, irq_n}, 8'h00);
    @(posedge clk); #2;
    chk("held_we_single_write", {7'b0, irq_n}, 8'h00);
    repeat (8) @(posedge clk);
    @(negedge clk); we = 1'b0; addr = 2'b00;
    @(negedge clk);
    bus_wr(2'b01, 8'h00);
    bus_wr(2'b01, 8'h80);
    chk("held_cleared", dout, 8'h00);

    // reset mid-count with irq active
    wr_reg(9'h002, 8'hFF);
    wr_reg(9'h004, 8'h01);
    repeat (6) @(negedge clk);
    chk("pre_rst_irq_n", {7'b0, irq_n}, 8'h00);
    rst_n = 1'b0; #1;
    chk("midrst_irq_n", {7'b0, irq_n}, 8'h01);
    chk("midrst_status", dout, 8'h00);
    chk("midrst_count", count_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_irq_n", {7'b0, irq_n}, 8'h01);
    chk("post_rst_count", count_out, 8'h00);

    // random bus traffic
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      count_sel = 2'($urandom_range(0, 3));
      if (r < 2) begin
        we   = 1'b1;
        addr = {($urandom_range(0, 7) == 0), 1'b0};
        din  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(2, 5));
      end else if (r < 4) begin
        we   = 1'b1;
        addr = 2'b01;
        din  = 8'($urandom);
        if ($urandom_range(0, 1) == 1) din[7:4] = 4'hF;
      end else begin
        if (r != 4) we = 1'b0;
        addr = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk); we = 1'b0; addr = 2'b00;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
